// File: rtl/id_ex_pipeline_reg_pkg.sv
// Shared definitions for the ID/EX stage: control bundle layout, opcodes, extend modes.
package id_ex_pipeline_reg_pkg;

    localparam int unsigned CTRL_W     = 25;
    localparam int unsigned IMM_W      = 16;
    localparam int unsigned SA_W       = 5;
    localparam int unsigned BUB_CNT_W  = 16;

    // Control bit positions (MSB first, matching ctrl_t field order)
    localparam int unsigned CTRL_ALU_EN       = 24;
    localparam int unsigned CTRL_ALU_SRC_A_HI = 23;
    localparam int unsigned CTRL_ALU_SRC_A_LO = 22;
    localparam int unsigned CTRL_ALU_SRC_B    = 21;
    localparam int unsigned CTRL_ALU_DST_HI   = 20;
    localparam int unsigned CTRL_ALU_DST_LO   = 19;
    localparam int unsigned CTRL_ALU_OP_HI    = 18;
    localparam int unsigned CTRL_ALU_OP_LO    = 15;
    localparam int unsigned CTRL_AGU_EN       = 14;
    localparam int unsigned CTRL_AGU_SRC_ADDR = 13;
    localparam int unsigned CTRL_AGU_DST      = 12;
    localparam int unsigned CTRL_AGU_OP_HI    = 11;
    localparam int unsigned CTRL_AGU_OP_LO    = 9;
    localparam int unsigned CTRL_JUMP         = 8;
    localparam int unsigned CTRL_BRANCH       = 7;
    localparam int unsigned CTRL_EXT_HI       = 6;
    localparam int unsigned CTRL_EXT_LO       = 5;
    localparam int unsigned CTRL_MEM_OP       = 4;
    localparam int unsigned CTRL_MEM_TYPE     = 3;
    localparam int unsigned CTRL_MEM_SIZE_HI  = 2;
    localparam int unsigned CTRL_MEM_SIZE_LO  = 1;
    localparam int unsigned CTRL_UNSIGN       = 0;

    localparam logic [3:0] OP_SLL  = 4'b0000;
    localparam logic [3:0] OP_SRL  = 4'b0001;
    localparam logic [3:0] OP_SRA  = 4'b0010;
    localparam logic [3:0] OP_ADD  = 4'b0011;
    localparam logic [3:0] OP_ADDU = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0101;
    localparam logic [3:0] OP_SUBU = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_OR   = 4'b1000;
    localparam logic [3:0] OP_XOR  = 4'b1001;
    localparam logic [3:0] OP_NOR  = 4'b1010;
    localparam logic [3:0] OP_SLT  = 4'b1011;
    localparam logic [3:0] OP_SLTU = 4'b1100;
    localparam logic [3:0] OP_LUI  = 4'b1101;

    localparam logic [2:0] AGU_OP_ADD  = 3'b000;
    localparam logic [2:0] AGU_OP_PC4  = 3'b001;
    localparam logic [2:0] AGU_OP_JR   = 3'b010;
    localparam logic [2:0] AGU_OP_JMP  = 3'b011;
    localparam logic [2:0] AGU_OP_BEQ  = 3'b100;
    localparam logic [2:0] AGU_OP_BNE  = 3'b101;

    localparam logic [1:0] MODE_ZERO  = 2'b00;
    localparam logic [1:0] MODE_SIGN  = 2'b01;
    localparam logic [1:0] MODE_UPPER = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic       alu_en;
        logic [1:0] alu_src_a;
        logic       alu_src_b;
        logic [1:0] alu_dst;
        logic [3:0] alu_op;
        logic       agu_en;
        logic       agu_src_addr;
        logic       agu_dst;
        logic [2:0] agu_op;
        logic       jump;
        logic       branch;
        logic [1:0] extend_sign;
        logic       mem_op;
        logic       mem_type;
        logic [1:0] mem_size;
        logic       unsign;
    } ctrl_t;

endpackage

// File: rtl/id_ex_pipeline_reg_load_use_detector.sv
// Combinational load-use hazard detection between the load in EX and the consumer in ID.
module load_use_detector
    import id_ex_pipeline_reg_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  ex_valid,
    input  logic                  ex_mem_op,
    input  logic                  ex_mem_type,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_rs_used,
    input  logic                  id_rt_used,
    output logic                  hazard_c
);

    logic ex_is_load_c;
    logic src_match_c;

    assign ex_is_load_c = ex_valid & ex_mem_op & ~ex_mem_type;
    assign src_match_c  = (id_rs_used & (id_rs == ex_rt)) | (id_rt_used & (id_rt == ex_rt));

    // Writes to $zero are discarded, so they never create a dependency
    assign hazard_c = ex_is_load_c & id_valid & src_match_c
                    & (ex_rt != REG_ADDR_W'(REG_ZERO));

endmodule

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register with load-use bubble insertion, flush and downstream stall.
// Optional bubble counter output enabled by defining ID_EX_BUBBLE_CNT_EN.
module id_ex_pipeline_reg
    import id_ex_pipeline_reg_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_valid,
    input  logic [CTRL_W-1:0]     i_ctrl,
    input  logic [DATA_W-1:0]     i_pc4,
    input  logic [DATA_W-1:0]     i_rs_data,
    input  logic [DATA_W-1:0]     i_rt_data,
    input  logic [IMM_W-1:0]      i_imm,
    input  logic [SA_W-1:0]       i_sa,
    input  logic [REG_ADDR_W-1:0] i_rs,
    input  logic [REG_ADDR_W-1:0] i_rt,
    input  logic [REG_ADDR_W-1:0] i_rd,
    input  logic                  i_rs_used,
    input  logic                  i_rt_used,
    input  logic                  i_flush,
    input  logic                  i_ex_stall,
    output logic                  o_stall,
    output logic                  o_valid,
    output logic [CTRL_W-1:0]     o_ctrl,
    output logic [DATA_W-1:0]     o_pc4,
    output logic [DATA_W-1:0]     o_rs_data,
    output logic [DATA_W-1:0]     o_rt_data,
    output logic [IMM_W-1:0]      o_imm,
    output logic [SA_W-1:0]       o_sa,
    output logic [REG_ADDR_W-1:0] o_rs,
    output logic [REG_ADDR_W-1:0] o_rt,
    output logic [REG_ADDR_W-1:0] o_rd
`ifdef ID_EX_BUBBLE_CNT_EN
    ,
    output logic [BUB_CNT_W-1:0]  o_bubble_cnt
`endif
);

    ctrl_t ctrl_q;
    logic  hazard_c;

    assign o_ctrl = ctrl_q;

    load_use_detector #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_load_use_detector (
        .ex_valid    (o_valid),
        .ex_mem_op   (ctrl_q.mem_op),
        .ex_mem_type (ctrl_q.mem_type),
        .ex_rt       (o_rt),
        .id_valid    (i_valid),
        .id_rs       (i_rs),
        .id_rt       (i_rt),
        .id_rs_used  (i_rs_used),
        .id_rt_used  (i_rt_used),
        .hazard_c    (hazard_c)
    );

    // A flush kills the consumer, so its hazard must not freeze the front end
    assign o_stall = (hazard_c & ~i_flush) | i_ex_stall;

    // Priority: reset, flush, downstream stall, hazard bubble, normal capture
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_valid   <= 1'b0;
            ctrl_q    <= '0;
            o_pc4     <= '0;
            o_rs_data <= '0;
            o_rt_data <= '0;
            o_imm     <= '0;
            o_sa      <= '0;
            o_rs      <= '0;
            o_rt      <= '0;
            o_rd      <= '0;
        end else if (i_flush) begin
            o_valid <= 1'b0;
            ctrl_q  <= '0;
        end else if (i_ex_stall) begin
            o_valid <= o_valid;
        end else if (hazard_c) begin
            o_valid <= 1'b0;
            ctrl_q  <= '0;
        end else begin
            o_valid   <= i_valid;
            ctrl_q    <= i_valid ? ctrl_t'(i_ctrl) : '0;
            o_pc4     <= i_pc4;
            o_rs_data <= i_rs_data;
            o_rt_data <= i_rt_data;
            o_imm     <= i_imm;
            o_sa      <= i_sa;
            o_rs      <= i_rs;
            o_rt      <= i_rt;
            o_rd      <= i_rd;
        end
    end

`ifdef ID_EX_BUBBLE_CNT_EN
    logic bubble_ins_c;

    assign bubble_ins_c = i_flush | (~i_ex_stall & hazard_c);

    // Saturating count of inserted bubbles
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_bubble_cnt <= '0;
        end else if (bubble_ins_c && (o_bubble_cnt != {BUB_CNT_W{1'b1}})) begin
            o_bubble_cnt <= o_bubble_cnt + BUB_CNT_W'(1);
        end
    end
`endif

endmodule
